stack_arb_ctrl: RTL

STACK_ARB_CTRL -- requirements
Module: stack_arb_ctrl

---
 rtl/stack_arb_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/stack_arb_ctrl.sv
// -----------------------------------------------------------------------------
// stack_arb_ctrl
//   Two-requester arbiter in front of a LIFO stack of 8-bit entries kept in an
//   external single-port SRAM. One operation is in flight at a time: IDLE picks
//   a winner, ACCESS drives the SRAM (or rejects the operation), READ captures
//   pop data, and DONE pulses completion.
//
//   Compile-time option:
//     STACK_ARB_FIXED_PRIO_EN  defined   -> fixed priority, A over B
//                              undefined -> round-robin on ties (A wins the
//                                           first tie after reset)
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   req_a/b, op_a/b, wdata_a/b request, op (1 = push, 0 = pop), push data
//   gnt_a/b                    one-cycle grant pulse (ACCESS cycle)
//   done, err                  completion pulse; err marks a rejected op
//   rdata                      last successfully popped byte
//   sram_ce/we/addr/wdata      SRAM command; sram_rdata arrives one cycle later
//   empty, full                stack pointer status
// -----------------------------------------------------------------------------
module stack_arb_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  input  logic          op_a,
  input  logic          op_b,
  input  logic [7:0]    wdata_a,
  input  logic [7:0]    wdata_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          done,
  output logic          err,
  output logic [7:0]    rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [7:0]    sram_wdata,
  input  logic [7:0]    sram_rdata,
  output logic          empty,
  output logic          full
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_READ   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [AW:0] SP_FULL = (AW+1)'(DEPTH);

  state_t      state_q, state_d;
  logic [AW:0] sp_q;        // 0..DEPTH, one extra bit so full never wraps
  logic        win_b_q;     // latched winner: 1 = B
  logic        op_q;        // latched operation
  logic        err_q;       // latched rejection, reported in DONE

  logic        any_req;
  logic        pick_b;
  logic        sel_op;
  logic [7:0]  sel_data;
  logic        sel_rej;
  logic        rej;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_FULL);
  assign any_req = req_a | req_b;

`ifdef STACK_ARB_FIXED_PRIO_EN
  assign pick_b = ~req_a;
`else
  logic last_b_q;           // last served requester: 1 = B

  // Only B requesting, or a tie where A was served last.
  assign pick_b = req_b & (~req_a | ~last_b_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_b_q <= 1'b1;     // so A wins the first tie
    end else if (state_q == S_ACCESS) begin
      last_b_q <= win_b_q;  // rejected operations still count as served
    end
  end
`endif

  assign sel_op   = pick_b ? op_b    : op_a;
  assign sel_data = pick_b ? wdata_b : wdata_a;
  // sp is stable between IDLE and ACCESS, so the rejection decided here for
  // the SRAM address/data registers matches the one taken in ACCESS.
  assign sel_rej  = sel_op ? full : empty;
  assign rej      = op_q   ? full : empty;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = (!op_q && !rej) ? S_READ : S_DONE;
      S_READ:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from state so reset drops the SRAM strobes at once)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;
    sram_ce = 1'b0;
    sram_we = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      S_ACCESS: begin
        gnt_a   = ~win_b_q;
        gnt_b   =  win_b_q;
        sram_ce = ~rej;
        sram_we = ~rej & op_q;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // sram_addr/sram_wdata are loaded when the winner is latched, so they are
  // valid throughout ACCESS and hold their last value otherwise. The push data
  // lives only in sram_wdata; a rejected push leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q       <= '0;
      rdata      <= '0;
      win_b_q    <= 1'b0;
      op_q       <= 1'b0;
      err_q      <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            win_b_q <= pick_b;
            op_q    <= sel_op;
            if (!sel_rej) begin
              if (sel_op) begin
                sram_addr  <= sp_q[AW-1:0];
                sram_wdata <= sel_data;
              end else begin
                sram_addr  <= AW'(sp_q - 1'b1);
              end
            end
          end
        end
        S_ACCESS: begin
          err_q <= rej;
          if (!rej && op_q) sp_q <= sp_q + 1'b1;
        end
        S_READ: begin
          rdata <= sram_rdata;
          sp_q  <= sp_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
